// File: rtl/pwmdir_decoder.sv
// PWM/DIR receive decoder: measures PWM high time and period in clk cycles and
// publishes a signed duty command. Optional glitch filter: PWMDIR_DEC_FILTER_EN.
module pwmdir_decoder #(
  parameter int TIMEOUT    = 200000,
  parameter int CNT_W      = 32,
  parameter int FILTER_LEN = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic                PWM,
  input  logic                DIR,
  output logic signed [31:0]  jointFeedback,
  output logic [CNT_W-1:0]    period_meas,
  output logic                valid,
  output logic                stale
);

  // state | meaning
  // IDLE  | no measurement open, waiting for a rising edge
  // HIGH  | PWM high phase of an open period
  // LOW   | PWM low phase, next rising edge closes the period
  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  localparam logic [CNT_W-1:0] TO = CNT_W'(TIMEOUT);

  state_t           state;
  logic             pwm_s1, pwm_s2, dir_s1, dir_s2;
  logic             pwm_f, dir_f, pwm_d;
  logic             rise, fall;
  logic             dir_l;
  logic [CNT_W-1:0] hi_cnt, per_cnt, hi_lat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_s1 <= 1'b0;
      pwm_s2 <= 1'b0;
      dir_s1 <= 1'b0;
      dir_s2 <= 1'b0;
    end else if (!enable) begin
      pwm_s1 <= 1'b0;
      pwm_s2 <= 1'b0;
      dir_s1 <= 1'b0;
      dir_s2 <= 1'b0;
    end else begin
      pwm_s1 <= PWM;
      pwm_s2 <= pwm_s1;
      dir_s1 <= DIR;
      dir_s2 <= dir_s1;
    end
  end

`ifdef PWMDIR_DEC_FILTER_EN
  localparam int FW = $clog2(FILTER_LEN + 1);

  logic [FW-1:0] pwm_fc, dir_fc;
  logic          pwm_fl, dir_fl;

  // level follows the synced input only after FILTER_LEN consecutive differing samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_fc <= '0;
      dir_fc <= '0;
      pwm_fl <= 1'b0;
      dir_fl <= 1'b0;
    end else if (!enable) begin
      pwm_fc <= '0;
      dir_fc <= '0;
      pwm_fl <= 1'b0;
      dir_fl <= 1'b0;
    end else begin
      if (pwm_s2 == pwm_fl) begin
        pwm_fc <= '0;
      end else if (pwm_fc == FW'(FILTER_LEN - 1)) begin
        pwm_fl <= pwm_s2;
        pwm_fc <= '0;
      end else begin
        pwm_fc <= pwm_fc + 1'b1;
      end
      if (dir_s2 == dir_fl) begin
        dir_fc <= '0;
      end else if (dir_fc == FW'(FILTER_LEN - 1)) begin
        dir_fl <= dir_s2;
        dir_fc <= '0;
      end else begin
        dir_fc <= dir_fc + 1'b1;
      end
    end
  end

  assign pwm_f = pwm_fl;
  assign dir_f = dir_fl;
`else
  if (FILTER_LEN < 1) begin : g_filter_len_unused
  end

  assign pwm_f = pwm_s2;
  assign dir_f = dir_s2;
`endif

  assign rise = pwm_f & ~pwm_d;
  assign fall = ~pwm_f & pwm_d;

  function automatic logic signed [31:0] to_fb(input logic [CNT_W-1:0] mag,
                                              input logic pos);
    logic signed [31:0] v;
    v = signed'(32'(mag));
    return pos ? v : -v;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      pwm_d         <= 1'b0;
      hi_cnt        <= '0;
      per_cnt       <= '0;
      hi_lat        <= '0;
      dir_l         <= 1'b0;
      jointFeedback <= '0;
      period_meas   <= '0;
      valid         <= 1'b0;
      stale         <= 1'b1;
    end else if (!enable) begin
      state         <= IDLE;
      pwm_d         <= 1'b0;
      hi_cnt        <= '0;
      per_cnt       <= '0;
      hi_lat        <= '0;
      dir_l         <= 1'b0;
      jointFeedback <= '0;
      period_meas   <= '0;
      valid         <= 1'b0;
      stale         <= 1'b1;
    end else begin
      valid <= 1'b0;
      pwm_d <= pwm_f;

      // the edge cycle is cycle 1 of the new interval
      if (rise) begin
        per_cnt <= CNT_W'(1);
        hi_cnt  <= CNT_W'(1);
      end else begin
        if (per_cnt != TO) per_cnt <= per_cnt + 1'b1;
        if (pwm_f && hi_cnt != TO) hi_cnt <= hi_cnt + 1'b1;
      end

      case (state)
        IDLE: begin
          if (rise) state <= HIGH;
        end
        HIGH: begin
          if (fall) begin
            dir_l  <= dir_f;
            hi_lat <= hi_cnt;
            state  <= LOW;
          end else if (per_cnt == TO) begin
            jointFeedback <= to_fb(period_meas, dir_f);
            valid         <= 1'b1;
            stale         <= 1'b1;
            state         <= IDLE;
          end
        end
        LOW: begin
          // edge takes priority over a coincident timeout
          if (rise) begin
            period_meas   <= per_cnt;
            jointFeedback <= to_fb(hi_lat, dir_l);
            valid         <= 1'b1;
            stale         <= 1'b0;
            state         <= HIGH;
          end else if (per_cnt == TO) begin
            jointFeedback <= '0;
            valid         <= 1'b1;
            stale         <= 1'b1;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pwmdir_decoder.sv
// Directed bench for pwmdir_decoder with TIMEOUT=256; expectations follow
// PWMDIR_DEC_FILTER_EN when the bench is built with it.
module tb_pwmdir_decoder;

  localparam int TO = 256;
  localparam int N  = 9;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               enable;
  logic               PWM;
  logic               DIR;
  logic signed [31:0] jointFeedback;
  logic [31:0]        period_meas;
  logic               valid;
  logic               stale;

  pwmdir_decoder #(.TIMEOUT(TO), .CNT_W(32), .FILTER_LEN(4)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .PWM(PWM), .DIR(DIR),
    .jointFeedback(jointFeedback), .period_meas(period_meas),
    .valid(valid), .stale(stale)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int nev   = 0;
  int ev_fb[64];
  int ev_per[64];
  int ev_st[64];
  int ev_cyc[64];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (valid && nev < 64) begin
      ev_fb[nev]  = jointFeedback;
      ev_per[nev] = int'(period_meas);
      ev_st[nev]  = int'(stale);
      ev_cyc[nev] = cyc;
      nev++;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, required $finish before it");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int   hi;
    int   per;
    logic dh;
    logic dl;
    int   fb;
  } vec_t;

  vec_t tab[N];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_ev(input string name, input int idx, input int fb,
                        input int per, input int st);
    if (idx >= nev) begin
      total++;
      bad++;
      $display("FAIL %s: event %0d missing, only %0d valid pulses seen", name, idx, nev);
    end else begin
      chk({name, ".fb"}, ev_fb[idx], fb);
      if (per >= 0) chk({name, ".period"}, ev_per[idx], per);
      chk({name, ".stale"}, ev_st[idx], st);
    end
  endtask

  task automatic drive(input int hi, input int lo, input logic dh, input logic dl);
    for (int j = 0; j < hi; j++) begin
      PWM = 1'b1; DIR = dh;
      @(posedge clk); #1;
    end
    for (int j = 0; j < lo; j++) begin
      PWM = 1'b0; DIR = (j < lo / 2) ? dh : dl;
      @(posedge clk); #1;
    end
  endtask

  int base;
  int g;

  initial begin
    tab[0] = '{30, 100, 1'b1, 1'b1, 30};
    tab[1] = '{30, 100, 1'b1, 1'b1, 30};
    tab[2] = '{30, 100, 1'b0, 1'b0, -30};
    tab[3] = '{30, 100, 1'b0, 1'b1, -30};
    tab[4] = '{30, 100, 1'b1, 1'b1, 30};
    tab[5] = '{5, 10, 1'b0, 1'b0, -5};
    tab[6] = '{200, 255, 1'b1, 1'b1, 200};
    tab[7] = '{10, 256, 1'b1, 1'b1, 10};
    tab[8] = '{50, 80, 1'b0, 1'b0, -50};

    rst_n = 1'b0; enable = 1'b1; PWM = 1'b0; DIR = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset.fb", jointFeedback, 0);
    chk("reset.period", int'(period_meas), 0);
    chk("reset.valid", int'(valid), 0);
    chk("reset.stale", int'(stale), 1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // table periods; entry i is reported at the rising edge of entry i+1
    for (int i = 0; i < N; i++) begin
      drive(tab[i].hi, tab[i].per - tab[i].hi, tab[i].dh, tab[i].dl);
      if (i == 0) begin
        chk("first_edge.no_valid", nev, 0);
        chk("first_edge.stale", int'(stale), 1);
      end
    end
    // closing edge, then PWM stuck low
    drive(30, 400, 1'b1, 1'b1);
    chk("table.count", nev, N + 1);
    for (int i = 0; i < N; i++) begin
      chk_ev($sformatf("vec%0d", i), i, tab[i].fb, tab[i].per, 0);
      if (i > 0) chk($sformatf("vec%0d.spacing", i), ev_cyc[i] - ev_cyc[i-1], tab[i].per);
    end
    chk("neg30.hex", ev_fb[2], int'(32'hFFFF_FFE2));
    chk_ev("stuck_low", N, 0, -1, 1);
    chk("stuck_low.delay", ev_cyc[N] - ev_cyc[N-1], TO);

    // stuck high after two periods of 100
    base = N + 1;
    drive(30, 70, 1'b1, 1'b1);
    drive(30, 70, 1'b1, 1'b1);
    drive(300, 0, 1'b1, 1'b1);
    chk_ev("sh.p1", base, 30, 100, 0);
    chk_ev("sh.p2", base + 1, 30, 100, 0);
    chk_ev("stuck_high", base + 2, 100, -1, 1);
    chk("stuck_high.delay", ev_cyc[base+2] - ev_cyc[base+1], TO);
    drive(0, 50, 1'b1, 1'b1);
    drive(30, 70, 1'b1, 1'b1);
    chk("resume.one_edge.count", nev, base + 3);
    chk("resume.one_edge.stale", int'(stale), 1);
    drive(30, 70, 1'b1, 1'b1);
    chk_ev("resume.second_edge", base + 3, 30, 100, 0);
    chk("resume.stale", int'(stale), 0);

    // asynchronous reset in the middle of a high phase
    drive(10, 0, 1'b1, 1'b1);
    chk_ev("pre_reset", base + 4, 30, 100, 0);
    rst_n = 1'b0; PWM = 1'b0;
    #1;
    chk("async_rst.fb", jointFeedback, 0);
    chk("async_rst.period", int'(period_meas), 0);
    chk("async_rst.valid", int'(valid), 0);
    chk("async_rst.stale", int'(stale), 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive(0, 60, 1'b1, 1'b1);
    drive(30, 70, 1'b1, 1'b1);
    chk("post_rst.one_edge.count", nev, base + 5);
    chk("post_rst.stale", int'(stale), 1);
    drive(30, 70, 1'b1, 1'b1);
    chk_ev("post_rst.second_edge", base + 5, 30, 100, 0);

    // 2-cycle glitch in the low phase
    drive(30, 30, 1'b1, 1'b1);
    drive(2, 38, 1'b1, 1'b1);
    drive(30, 70, 1'b1, 1'b1);
    chk_ev("glitch.prev", base + 6, 30, 100, 0);
`ifdef PWMDIR_DEC_FILTER_EN
    chk("glitch.count", nev, base + 8);
    chk_ev("glitch.filtered", base + 7, 30, 100, 0);
    g = base + 8;
`else
    chk("glitch.count", nev, base + 9);
    chk_ev("glitch.short1", base + 7, 30, 60, 0);
    chk_ev("glitch.short2", base + 8, 2, 40, 0);
    g = base + 9;
`endif

    // synchronous disable
    enable = 1'b0;
    @(posedge clk); #1;
    chk("disable.fb", jointFeedback, 0);
    chk("disable.period", int'(period_meas), 0);
    chk("disable.stale", int'(stale), 1);
    enable = 1'b1;
    drive(30, 70, 1'b1, 1'b1);
    chk("disable.no_valid", nev, g);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pwmdir_decoder.md
Name: pwmdir_decoder

Overview:
- Receive side of the joint PWM/DIR interface. Recovers a signed duty command from an external PWM + DIR pair, e.g. a second board or a loopback of a joint output.
- Measures high time and period of PWM in clk cycles. The sign comes from DIR.
- Publishes a signed value in the same units the PWM/DIR generator consumes: high-time cycles, positive when DIR=1.
- Sits between the input pins and the Remora feedback register file.

Parameters:
- TIMEOUT, 200000, cycles without a PWM rising edge before the input is declared stale (2x nominal period of 100000).
- CNT_W, 32, width of the internal counters and of period_meas.
- FILTER_LEN, 4, stable-sample count for the glitch filter (used only with PWMDIR_DEC_FILTER_EN).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- enable  input  1  decoder enable; 0 holds the block in IDLE with outputs cleared.
- PWM  input  1  raw PWM pin, asynchronous.
- DIR  input  1  raw direction pin, asynchronous.
- jointFeedback  output  32 signed  decoded command: +high_cycles if DIR=1, -high_cycles if DIR=0.
- period_meas  output  CNT_W  last measured period in clk cycles.
- valid  output  1  one-cycle pulse when jointFeedback/period_meas update.
- stale  output  1  high while no valid PWM activity (after reset, timeout, or enable=0).

Behaviour:
- Reset (rst_n=0, asynchronous): jointFeedback=0, period_meas=0, valid=0, stale=1, counters=0, synchronizers=0, state=IDLE.
- Input path:
  - PWM and DIR each pass through a 2-flop synchronizer, then an edge detector on synced PWM.
  - Rising-edge event is seen 3 clk after a clean raw edge (without filter).
- Counters:
  - hi_cnt counts cycles with synced PWM=1 since the last rising edge.
  - per_cnt counts all cycles since the last rising edge.
  - Both saturate at TIMEOUT and never wrap.
- DIR is latched (dir_l) on the synced PWM falling edge, i.e. at the end of the high phase.
- States:
  - IDLE: wait for a rising edge. On a rising edge, clear the counters and go to HIGH. No output update (first edge only opens a measurement).
  - HIGH:
    - Count. On a falling edge, latch dir_l and hi_cnt, then go to LOW.
    - If per_cnt reaches TIMEOUT (stuck high): jointFeedback = dir ? +period_meas : -period_meas (full scale from the last period), valid pulse, stale=1, go to IDLE.
  - LOW:
    - On a rising edge: period_meas=per_cnt, jointFeedback = dir_l ? +hi_latched : -hi_latched, valid=1 for 1 cycle, stale=0, clear counters, go to HIGH.
    - If per_cnt reaches TIMEOUT (stuck low): jointFeedback=0, valid pulse, stale=1, go to IDLE.
- Counting convention: a cycle in which the edge is detected counts as cycle 1 of the new interval. A generator high time of N cycles therefore decodes to exactly N, and a period of P decodes to P.
- Sign rule: DIR=0 with hi=0 yields 0, never -0 ambiguity; the value is two's complement.
- Simultaneous rising edge and timeout in the same cycle: the edge wins and is treated as a valid period.
- enable=0: same clearing as reset, but synchronous. Outputs are zeroed the next cycle, stale=1, state IDLE.
- Reset mid-measurement discards the partial period. The next output needs two rising edges.
- jointFeedback magnitude is ≤ TIMEOUT, so it always fits 32 bits signed.

Optional Feature:
- Macro: PWMDIR_DEC_FILTER_EN.
- Defined:
  - Synced PWM and DIR each feed a glitch filter. The filtered level changes only after FILTER_LEN consecutive equal samples.
  - Edge latency grows by FILTER_LEN cycles.
  - Pulses shorter than FILTER_LEN are ignored.
  - Measured high time and period are unchanged for clean inputs, because both edges are delayed equally.
- Undefined: no filter, 3-cycle edge latency, every synced transition counts.

Test Plan:
- Clean PWM, period 100, high 30, DIR=1, after reset -> first valid on 2nd rising edge: jointFeedback=+30, period_meas=100, stale 1->0; valid once per period thereafter.
- Same waveform with DIR=0 -> jointFeedback=-30 (0xFFFFFFE2); toggle DIR mid low phase -> sign changes only on the period after the next high phase.
- TIMEOUT=256, PWM held low after two good periods (high 30) -> valid pulse with jointFeedback=0, stale=1 exactly 256 cycles after the last rising edge.
- TIMEOUT=256, PWM held high after periods of 100 -> jointFeedback=+100, stale=1; resume PWM -> two rising edges needed before stale=0.
- Assert rst_n low mid HIGH phase for 1 cycle -> all outputs 0 immediately (asynchronous), stale=1; next valid only after two rising edges.
- With PWMDIR_DEC_FILTER_EN, FILTER_LEN=4: insert 2-cycle glitches in the low phase -> jointFeedback unchanged (+30); without the macro the same stimulus produces an extra short-period update.
